// File: rtl/cfg_chain_pkg.sv
// Shared state encoding and sizing helpers for the configuration chain loader.
package cfg_chain_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StCommit,
      StWaitAck
   } cfg_state_e;

   localparam int unsigned CfgDefaultWordW   = 32;
   localparam int unsigned CfgDefaultChainLen = 1024;

   function automatic int unsigned cfg_num_words(input int unsigned chain_len,
                                                 input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   // Bits carried by the final word; equals word_w when the chain is a whole number of words.
   function automatic int unsigned cfg_last_bits(input int unsigned chain_len,
                                                 input int unsigned word_w);
      return chain_len - (cfg_num_words(chain_len, word_w) - 1) * word_w;
   endfunction

endpackage

// File: rtl/cfg_piso.sv
// Word-wide shift register with parallel load, right shift (serial in at the MSB) and a
// count of shifts since the last load. Serves as the PISO and, mirrored, the readback SIPO.
module cfg_piso #(
   parameter int unsigned Width = 32,
   parameter int unsigned CntW  = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [Width-1:0] data_i,
   input  logic             ser_i,
   output logic             ser_o,
   output logic [Width-1:0] nxt_o,
   output logic [CntW-1:0]  cnt_o
);

   logic [Width-1:0] sreg_q, sreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   always_comb begin
      nxt_o            = sreg_q >> 1;
      nxt_o[Width-1]   = ser_i;
      sreg_d           = sreg_q;
      cnt_d            = cnt_q;
      if (load_i) begin
         sreg_d = data_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         sreg_d = nxt_o;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign ser_o = sreg_q[0];
   assign cnt_o = cnt_q;

endmodule

// File: rtl/config_chain_loader.sv
// Master end of the fabric config chain: serialises bitstream words LSB-first, pulses cset and
// waits for the echo on cset_ack. Define CFG_READBACK_EN to capture the old chain contents.
module config_chain_loader
   import cfg_chain_pkg::*;
#(
   parameter int unsigned WORD_W    = CfgDefaultWordW,
   parameter int unsigned CHAIN_LEN = CfgDefaultChainLen
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              cset_ack,
   output logic              shift_in,
   output logic              cen,
   output logic              cset,
   output logic              busy,
   output logic              done
`ifdef CFG_READBACK_EN
   ,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              shift_out
`endif
);

   localparam int unsigned NUM_WORDS  = cfg_num_words(CHAIN_LEN, WORD_W);
   localparam int unsigned LAST_BITS  = cfg_last_bits(CHAIN_LEN, WORD_W);
   localparam int unsigned LAST_PAD   = WORD_W - LAST_BITS;
   localparam int unsigned BIT_CNT_W  = $clog2(WORD_W + 1);
   localparam int unsigned WORD_CNT_W = $clog2(NUM_WORDS + 1);

   localparam logic [BIT_CNT_W-1:0]  FullMax  = BIT_CNT_W'(WORD_W - 1);
   localparam logic [BIT_CNT_W-1:0]  LastMax  = BIT_CNT_W'(LAST_BITS - 1);
   localparam logic [WORD_CNT_W-1:0] LastIdx  = WORD_CNT_W'(NUM_WORDS - 1);
   localparam logic [WORD_W-1:0]     LastMask = {WORD_W{1'b1}} >> LAST_PAD;

   cfg_state_e              state_q;
   logic [WORD_CNT_W-1:0]   word_cnt_q;
   logic                    in_ready_q;
   logic                    cen_q;
   logic                    cset_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    accept;
   logic                    last_word;
   logic                    last_bit;
   logic                    piso_shift;
   logic [WORD_W-1:0]       piso_data;
   logic [BIT_CNT_W-1:0]    bit_cnt;
   logic [WORD_W-1:0]       unused_piso_nxt;

   always_comb begin
      accept     = (state_q == StLoad) && in_valid && in_ready_q;
      last_word  = (word_cnt_q == LastIdx);
      piso_shift = (state_q == StShift);
      last_bit   = piso_shift && (bit_cnt == (last_word ? LastMax : FullMax));
      // Masking the unused top bits leaves the register empty after the last shift, so
      // shift_in can come straight from bit 0 and still read 0 outside SHIFT.
      piso_data  = last_word ? (in_data & LastMask) : in_data;
   end

   cfg_piso #(
      .Width (WORD_W),
      .CntW  (BIT_CNT_W)
   ) u_piso (
      .clk_i   (clk),
      .rst_ni  (rst),
      .load_i  (accept),
      .shift_i (piso_shift),
      .data_i  (piso_data),
      .ser_i   (1'b0),
      .ser_o   (shift_in),
      .nxt_o   (unused_piso_nxt),
      .cnt_o   (bit_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         in_ready_q <= 1'b0;
         cen_q      <= 1'b0;
         cset_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StLoad;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
                  word_cnt_q <= '0;
               end
            end
            StLoad: begin
               if (accept) begin
                  state_q    <= StShift;
                  in_ready_q <= 1'b0;
                  cen_q      <= 1'b1;
               end
            end
            StShift: begin
               if (last_bit) begin
                  cen_q      <= 1'b0;
                  word_cnt_q <= word_cnt_q + 1'b1;
                  if (last_word) begin
                     state_q <= StCommit;
                     cset_q  <= 1'b1;
                  end else begin
                     state_q    <= StLoad;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            StCommit: begin
               cset_q  <= 1'b0;
               state_q <= StWaitAck;
            end
            StWaitAck: begin
               if (cset_ack) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign cen      = cen_q;
   assign cset     = cset_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef CFG_READBACK_EN
   logic [WORD_W-1:0]    sipo_nxt;
   logic                 unused_sipo_ser;
   logic [BIT_CNT_W-1:0] unused_sipo_cnt;
   logic [WORD_W-1:0]    rd_data_q;
   logic                 rd_valid_q;

   // Bits enter at the MSB, so a short last word must be right-aligned on its way out.
   cfg_piso #(
      .Width (WORD_W),
      .CntW  (BIT_CNT_W)
   ) u_sipo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .load_i  (accept),
      .shift_i (piso_shift),
      .data_i  ({WORD_W{1'b0}}),
      .ser_i   (shift_out),
      .ser_o   (unused_sipo_ser),
      .nxt_o   (sipo_nxt),
      .cnt_o   (unused_sipo_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= last_bit;
         if (last_bit) begin
            rd_data_q <= last_word ? (sipo_nxt >> LAST_PAD) : sipo_nxt;
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Master end of the fabric configuration shift chain. Drives the serial config inputs of daisy-chained connection and switch blocks: shift_in, cen and cset.
- Accepts the bitstream as parallel words over a valid/ready stream.
- Serializes exactly CHAIN_LEN bits into the chain, then pulses cset to commit.
- Waits for the commit to propagate back on the last block's cset_out before reporting done.
- Sits between the bitstream source (wishbone/SPI bridge) and the first fabric tile.

Parameters:
- WORD_W, 32, width of bitstream words accepted on in_data.
- CHAIN_LEN, 1024, total config bits in the chain (must be >= 1).
- NUM_WORDS, (CHAIN_LEN+WORD_W-1)/WORD_W, derived; words per load.
- BIT_CNT_W, $clog2(WORD_W+1), derived.
- WORD_CNT_W, $clog2(NUM_WORDS+1), derived.

Ports:
- clk  input  1  single clock for loader and chain.
- rst  input  1  reset; synchronous, active-low (asserted when 0).
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- in_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- cset_ack  input  1  cset_out of the last block in the chain.
- shift_in  output  1  serial config bit to the chain.
- cen  output  1  chain shift enable.
- cset  output  1  commit strobe to the chain.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the commit is acknowledged.
- rd_data  output  WORD_W  readback word; present only under CFG_READBACK_EN.
- rd_valid  output  1  readback word valid pulse; present only under CFG_READBACK_EN.
- shift_out  input  1  serial output of the last block; present only under CFG_READBACK_EN.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - All outputs 0: in_ready, shift_in, cen, cset, busy, done, rd_valid, rd_data.
  - Counters cleared.
- Reset mid-load aborts immediately. Chain contents are then undefined, and cset is never issued for a partial load.
- FSM states: IDLE, LOAD, SHIFT, COMMIT, WAIT_ACK.
- IDLE:
  - start=1 -> LOAD, busy=1, word_cnt=0.
  - start during any other state is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register, then go to SHIFT.
  - bits_this_word = WORD_W, or on the last word CHAIN_LEN-(NUM_WORDS-1)*WORD_W.
  - Upper unused bits of a partial last word are discarded.
- SHIFT:
  - Each cycle: cen=1, shift_in=sreg[0], sreg>>=1, bit_cnt++.
  - cen and shift_in are registered outputs, valid in the same cycles.
  - When bit_cnt reaches bits_this_word: word_cnt++.
    - If word_cnt==NUM_WORDS -> COMMIT.
    - Else -> LOAD.
  - in_ready=0 throughout SHIFT.
  - Per-word cost: 1 accept cycle + bits_this_word shift cycles.
  - Total cen-high cycles per load is exactly CHAIN_LEN.
- COMMIT: cset=1 for exactly one cycle, cen=0, then -> WAIT_ACK.
- WAIT_ACK:
  - Stays until cset_ack==1.
  - Then done=1 for one cycle, busy=0, -> IDLE.
  - cset_ack already high on the first WAIT_ACK cycle completes immediately.
  - No timeout.
- Bit order: first bit shifted ends at the far end of the chain (chain position CHAIN_LEN-1).
- in_valid may drop between words; the loader stalls in LOAD with cen=0 and the chain holds.
- cen=0 and shift_in=0 in every state except SHIFT.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - During every SHIFT cycle, shift_out is captured LSB-first into a readback register.
  - rd_data/rd_valid pulse once per word, on the cycle after its last bit.
  - The partial last word is zero-padded in its upper bits.
  - Yields the previous chain contents in load order.
  - No back-pressure on rd_data.
- Undefined: shift_out, rd_data and rd_valid ports are absent; no capture logic.

Decomposition:
- Package cfg_chain_pkg: FSM state enum (IDLE/LOAD/SHIFT/COMMIT/WAIT_ACK) and a localparam function computing NUM_WORDS and last-word bit count.
- One natural sub-module: cfg_piso (WORD_W parallel-in/serial-out shift register with load, shift and count).
  - Reused, mirrored, as the SIPO for readback.

Test Plan:
- CHAIN_LEN=64, WORD_W=32; send 0xDEADBEEF then 0x12345678 -> 64 cen cycles. shift_in follows 0xDEADBEEF LSB-first, then 0x12345678; one cset pulse; done after cset_ack.
- CHAIN_LEN=40, WORD_W=32, words 0xFFFFFFFF and 0xFFFFFFAA -> second word shifts only 8 bits (0xAA LSB-first); total 40 cen cycles.
- in_valid held low for 10 cycles between words -> cen=0 for those cycles, no extra bits shifted, final chain model matches.
- rst driven low during the 5th shift cycle of word 1 -> next cycle all outputs 0, no cset. A subsequent full load completes correctly.
- cset_ack delayed 7 cycles after cset -> busy stays 1, done pulses exactly once, 1 cycle after cset_ack rises. A start pulse during the wait is ignored.
- CFG_READBACK_EN, chain model preloaded with 0xCAFEF00D, 0x0BADBEEF -> rd_data 0xCAFEF00D then 0x0BADBEEF, each with a one-cycle rd_valid.
